// File: rtl/guvm_obi_mem_responder_if.sv
// Request/grant/response bus between a core memory port and the memory responder.
// Signal names mirror the responder's port list so traces line up with the core side.
interface guvm_obi_mem_responder_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
);
  logic                    req_i;
  logic [ADDR_WIDTH-1:0]   addr_i;
  logic                    we_i;
  logic [DATA_WIDTH/8-1:0] be_i;
  logic [DATA_WIDTH-1:0]   wdata_i;
  logic                    gnt_o;
  logic                    rvalid_o;
  logic [DATA_WIDTH-1:0]   rdata_o;
  logic                    err_o;

  modport master (
    output req_i, addr_i, we_i, be_i, wdata_i,
    input  gnt_o, rvalid_o, rdata_o, err_o
  );

  modport slave (
    input  req_i, addr_i, we_i, be_i, wdata_i,
    output gnt_o, rvalid_o, rdata_o, err_o
  );
endinterface

// File: rtl/guvm_obi_mem_responder.sv
// Cycle-accurate memory responder: programmable grant/response latency, outstanding limit,
// byte-enable writes, out-of-range error responses, backdoor preload and transaction counters.
module guvm_obi_mem_responder #(
  parameter int unsigned ADDR_WIDTH      = 32,
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned MEM_DEPTH       = 1024,
  parameter int unsigned GNT_DELAY       = 0,
  parameter int unsigned RVALID_DELAY    = 1,
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter logic [31:0] ERR_DATA        = 32'hDEADBEEF,
  localparam int unsigned IdxW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1,
  localparam int unsigned OutW = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  guvm_obi_mem_responder_if.slave    bus,
  input  logic                       bd_we_i,
  input  logic [IdxW-1:0]            bd_addr_i,
  input  logic [DATA_WIDTH-1:0]      bd_wdata_i,
  output logic [31:0]                rd_count_o,
  output logic [31:0]                wr_count_o,
  output logic [OutW-1:0]            outstanding_o
);

  localparam int unsigned BeW  = DATA_WIDTH / 8;
  localparam int unsigned OffW = $clog2(BeW);
  localparam int unsigned CntW = (GNT_DELAY > 0) ? $clog2(GNT_DELAY + 1) : 1;
  localparam logic [DATA_WIDTH-1:0] ErrWord = DATA_WIDTH'(ERR_DATA);
  localparam logic [OutW-1:0]       MaxOut  = OutW'(MAX_OUTSTANDING);
  localparam logic [CntW-1:0]       GntDly  = CntW'(GNT_DELAY);

  typedef enum logic [0:0] {StIdle, StWait} state_e;

  typedef struct packed {
    logic                  vld;
    logic                  err;
    logic [DATA_WIDTH-1:0] data;
  } desc_t;

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  state_e          state_q, state_d;
  logic [CntW-1:0] wait_cnt_q, wait_cnt_d;
  logic [OutW-1:0] outstanding_q, outstanding_d;
  logic [31:0]     rd_count_q, wr_count_q;
  desc_t           pipe_q [RVALID_DELAY];
  desc_t           feed   [RVALID_DELAY];

  logic [ADDR_WIDTH-1:0] word;
  logic [IdxW-1:0]       word_idx;
  logic                  dec_err;
  logic                  eligible;
  logic                  has_space;
  logic                  gnt;
  logic                  hs;
  logic                  rvalid;

  assign word     = bus.addr_i >> OffW;
  assign word_idx = word[IdxW-1:0];
  assign dec_err  = word >= ADDR_WIDTH'(MEM_DEPTH);
  assign rvalid   = pipe_q[RVALID_DELAY-1].vld;

  // Grant FSM: the delay restarts whenever req drops or a handshake completes.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    eligible   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.req_i) begin
          if (GNT_DELAY == 0) begin
            eligible = 1'b1;
          end else begin
            state_d    = StWait;
            wait_cnt_d = CntW'(1);
          end
        end
      end
      StWait: begin
        if (!bus.req_i) begin
          state_d    = StIdle;
          wait_cnt_d = '0;
        end else if (wait_cnt_q == GntDly) begin
          eligible = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + CntW'(1);
        end
      end
      default: state_d = StIdle;
    endcase

    // A slot retiring this cycle may be reused immediately.
    has_space = (outstanding_q < MaxOut) || rvalid;
    gnt       = bus.req_i & eligible & has_space & ~rst_i;
    hs        = gnt;
    if (hs) begin
      state_d    = StIdle;
      wait_cnt_d = '0;
    end
  end

  always_comb begin
    outstanding_d = outstanding_q;
    case ({hs, rvalid})
      2'b10:   outstanding_d = outstanding_q + OutW'(1);
      2'b01:   outstanding_d = outstanding_q - OutW'(1);
      default: outstanding_d = outstanding_q;
    endcase
  end

  // Response delay line; reads see the pre-write memory value of the handshake edge.
  always_comb begin
    feed[0].vld  = hs;
    feed[0].err  = dec_err;
    feed[0].data = dec_err ? ErrWord : (bus.we_i ? '0 : mem[word_idx]);
    for (int i = 1; i < RVALID_DELAY; i++) begin
      feed[i] = pipe_q[i-1];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= StIdle;
      wait_cnt_q    <= '0;
      outstanding_q <= '0;
      rd_count_q    <= '0;
      wr_count_q    <= '0;
      for (int i = 0; i < RVALID_DELAY; i++) begin
        pipe_q[i] <= '0;
      end
    end else begin
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      outstanding_q <= outstanding_d;
      // Payload only moves with a valid descriptor, so the last stage holds the last response.
      for (int i = 0; i < RVALID_DELAY; i++) begin
        pipe_q[i].vld <= feed[i].vld;
        if (feed[i].vld) begin
          pipe_q[i].err  <= feed[i].err;
          pipe_q[i].data <= feed[i].data;
        end
      end
      if (hs && bus.we_i) begin
        wr_count_q <= wr_count_q + 32'd1;
      end
      if (hs && !bus.we_i) begin
        rd_count_q <= rd_count_q + 32'd1;
      end
    end
  end

  // Storage survives reset; the backdoor write is issued last so it wins on a collision.
  always_ff @(posedge clk_i) begin
    if (hs && bus.we_i && !dec_err) begin
      for (int b = 0; b < BeW; b++) begin
        if (bus.be_i[b]) begin
          mem[word_idx][8*b +: 8] <= bus.wdata_i[8*b +: 8];
        end
      end
    end
    if (bd_we_i) begin
      mem[bd_addr_i] <= bd_wdata_i;
    end
  end

  assign bus.gnt_o     = gnt;
  assign bus.rvalid_o  = rvalid;
  assign bus.rdata_o   = pipe_q[RVALID_DELAY-1].data;
  assign bus.err_o     = pipe_q[RVALID_DELAY-1].err;
  assign rd_count_o    = rd_count_q;
  assign wr_count_o    = wr_count_q;
  assign outstanding_o = outstanding_q;

endmodule

// File: tb/tb_guvm_obi_mem_responder.sv
// Directed bench for guvm_obi_mem_responder: three instances cover default timing,
// delayed grant with longer response latency, and the outstanding limit with reset flush.
module tb_guvm_obi_mem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst0, rst1, rst2;
  logic        bd_we0, bd_we1, bd_we2;
  logic [9:0]  bd_addr0;
  logic [5:0]  bd_addr1, bd_addr2;
  logic [31:0] bd_wdata0, bd_wdata1, bd_wdata2;
  logic [31:0] rd_cnt0, wr_cnt0, rd_cnt1, wr_cnt1, rd_cnt2, wr_cnt2;
  logic [1:0]  out0, out1, out2;

  int total = 0;
  int bad   = 0;
  logic [31:0] rsp2 [$];

  guvm_obi_mem_responder_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus0 ();
  guvm_obi_mem_responder_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus1 ();
  guvm_obi_mem_responder_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus2 ();

  guvm_obi_mem_responder u_dut0 (
    .clk_i(clk), .rst_i(rst0), .bus(bus0),
    .bd_we_i(bd_we0), .bd_addr_i(bd_addr0), .bd_wdata_i(bd_wdata0),
    .rd_count_o(rd_cnt0), .wr_count_o(wr_cnt0), .outstanding_o(out0)
  );

  guvm_obi_mem_responder #(
    .MEM_DEPTH(64), .GNT_DELAY(3), .RVALID_DELAY(2)
  ) u_dut1 (
    .clk_i(clk), .rst_i(rst1), .bus(bus1),
    .bd_we_i(bd_we1), .bd_addr_i(bd_addr1), .bd_wdata_i(bd_wdata1),
    .rd_count_o(rd_cnt1), .wr_count_o(wr_cnt1), .outstanding_o(out1)
  );

  guvm_obi_mem_responder #(
    .MEM_DEPTH(64), .MAX_OUTSTANDING(2), .RVALID_DELAY(4)
  ) u_dut2 (
    .clk_i(clk), .rst_i(rst2), .bus(bus2),
    .bd_we_i(bd_we2), .bd_addr_i(bd_addr2), .bd_wdata_i(bd_wdata2),
    .rd_count_o(rd_cnt2), .wr_count_o(wr_cnt2), .outstanding_o(out2)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic bd_write(input int which, input int idx, input logic [31:0] d);
    @(posedge clk); #1;
    case (which)
      0: begin bd_we0 = 1'b1; bd_addr0 = 10'(idx); bd_wdata0 = d; end
      1: begin bd_we1 = 1'b1; bd_addr1 = 6'(idx);  bd_wdata1 = d; end
      default: begin bd_we2 = 1'b1; bd_addr2 = 6'(idx); bd_wdata2 = d; end
    endcase
    @(posedge clk); #1;
    bd_we0 = 1'b0;
    bd_we1 = 1'b0;
    bd_we2 = 1'b0;
  endtask

  // One transfer on bus0; gc/rc are the grant and response latencies in cycles (-1 = none).
  task automatic xfer0(input logic w, input logic [3:0] be, input logic [31:0] a,
                       input logic [31:0] d, output logic [31:0] rd, output logic er,
                       output int gc, output int rc);
    rd = '0;
    er = 1'b0;
    gc = -1;
    rc = -1;
    @(posedge clk); #1;
    bus0.req_i   = 1'b1;
    bus0.we_i    = w;
    bus0.be_i    = be;
    bus0.addr_i  = a;
    bus0.wdata_i = d;
    for (int i = 0; i < 16 && gc < 0; i++) begin
      @(negedge clk);
      if (bus0.gnt_o) gc = i;
      else begin
        @(posedge clk); #1;
      end
    end
    @(posedge clk); #1;
    bus0.req_i = 1'b0;
    for (int i = 1; i < 16 && rc < 0; i++) begin
      @(negedge clk);
      if (bus0.rvalid_o) begin
        rc = i;
        rd = bus0.rdata_o;
        er = bus0.err_o;
      end else begin
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic pat1(input logic [15:0] req_pat, output logic [15:0] g, output logic [15:0] r);
    g = '0;
    r = '0;
    for (int c = 0; c < 16; c++) begin
      @(posedge clk); #1;
      bus1.req_i = req_pat[c];
      @(negedge clk);
      g[c] = bus1.gnt_o;
      r[c] = bus1.rvalid_o;
    end
    @(posedge clk); #1;
    bus1.req_i = 1'b0;
  endtask

  task automatic pat2(input logic [15:0] req_pat, input logic [15:0] rst_pat,
                      output logic [15:0] g, output logic [15:0] r, output logic [1:0] o2);
    int n;
    n  = 0;
    g  = '0;
    r  = '0;
    o2 = '0;
    rsp2.delete();
    for (int c = 0; c < 16; c++) begin
      @(posedge clk); #1;
      rst2        = rst_pat[c];
      bus2.req_i  = req_pat[c];
      bus2.addr_i = 32'(n * 4);
      @(negedge clk);
      g[c] = bus2.gnt_o;
      r[c] = bus2.rvalid_o;
      if (c == 2) o2 = out2;
      if (bus2.gnt_o) n++;
      if (bus2.rvalid_o) rsp2.push_back(bus2.rdata_o);
    end
    @(posedge clk); #1;
    bus2.req_i = 1'b0;
    rst2       = 1'b0;
  endtask

  initial begin
    logic [31:0] rd;
    logic        er;
    int          gc, rc;
    logic [15:0] g, r;
    logic [1:0]  o2;
    logic [31:0] v;

    rst0 = 1'b1; rst1 = 1'b1; rst2 = 1'b1;
    bd_we0 = 1'b0; bd_we1 = 1'b0; bd_we2 = 1'b0;
    bd_addr0 = '0; bd_addr1 = '0; bd_addr2 = '0;
    bd_wdata0 = '0; bd_wdata1 = '0; bd_wdata2 = '0;
    bus0.req_i = 1'b1; bus0.we_i = 1'b0; bus0.be_i = '0; bus0.addr_i = '0; bus0.wdata_i = '0;
    bus1.req_i = 1'b0; bus1.we_i = 1'b0; bus1.be_i = '0; bus1.addr_i = '0; bus1.wdata_i = '0;
    bus2.req_i = 1'b0; bus2.we_i = 1'b0; bus2.be_i = '0; bus2.addr_i = '0; bus2.wdata_i = '0;

    // Reset state, with a request pending to show the grant is held off.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_gnt", bus0.gnt_o, 1'b0);
    check("rst_rvalid", bus0.rvalid_o, 1'b0);
    check("rst_rdata", bus0.rdata_o, 32'h0);
    check("rst_err", bus0.err_o, 1'b0);
    check("rst_rd_cnt", rd_cnt0, 32'h0);
    check("rst_wr_cnt", wr_cnt0, 32'h0);
    check("rst_outst", out0, 2'd0);
    bus0.req_i = 1'b0;

    // Preloads are allowed while held in reset.
    bd_write(0, 3, 32'h002180B3);
    bd_write(1, 0, 32'hCAFE0001);
    for (int i = 0; i < 6; i++) bd_write(2, i, 32'hA0000000 + 32'(i));
    @(posedge clk); #1;
    rst0 = 1'b0; rst1 = 1'b0; rst2 = 1'b0;

    // Default timing read.
    xfer0(1'b0, 4'h0, 32'hC, 32'h0, rd, er, gc, rc);
    check("t1_gnt_lat", 32'(gc), 32'd0);
    check("t1_rv_lat", 32'(rc), 32'd1);
    check("t1_rdata", rd, 32'h002180B3);
    check("t1_err", er, 1'b0);
    check("t1_rd_cnt", rd_cnt0, 32'd1);
    check("t1_outst", out0, 2'd1);
    @(negedge clk);
    check("t1_rv_drop", bus0.rvalid_o, 1'b0);
    check("t1_rdata_hold", bus0.rdata_o, 32'h002180B3);
    check("t1_outst_free", out0, 2'd0);

    // Byte-enable write, then read back (low address bits ignored on the second read).
    bd_write(0, 0, 32'h11223344);
    xfer0(1'b1, 4'b0101, 32'h0, 32'hAABBCCDD, rd, er, gc, rc);
    check("t2_wr_rdata", rd, 32'h0);
    check("t2_wr_err", er, 1'b0);
    check("t2_wr_cnt", wr_cnt0, 32'd1);
    xfer0(1'b0, 4'h0, 32'h0, 32'h0, rd, er, gc, rc);
    check("t2_rdback", rd, 32'h11BB33DD);
    xfer0(1'b0, 4'h0, 32'h3, 32'h0, rd, er, gc, rc);
    check("t2_rdback_off", rd, 32'h11BB33DD);

    // Range boundary and error responses.
    bd_write(0, 1023, 32'h0BADF00D);
    xfer0(1'b0, 4'h0, 32'hFFC, 32'h0, rd, er, gc, rc);
    check("t5_last_rdata", rd, 32'h0BADF00D);
    check("t5_last_err", er, 1'b0);
    xfer0(1'b0, 4'h0, 32'h1000, 32'h0, rd, er, gc, rc);
    check("t5_rd_err", er, 1'b1);
    check("t5_rd_errdata", rd, 32'hDEADBEEF);
    xfer0(1'b1, 4'hF, 32'h1000, 32'h12345678, rd, er, gc, rc);
    check("t5_wr_err", er, 1'b1);
    check("t5_wr_errdata", rd, 32'hDEADBEEF);
    xfer0(1'b0, 4'h0, 32'h0, 32'h0, rd, er, gc, rc);
    check("t5_mem_kept", rd, 32'h11BB33DD);

    // Backdoor and bus write to the same word on the same edge.
    @(posedge clk); #1;
    bus0.req_i = 1'b1; bus0.we_i = 1'b1; bus0.be_i = 4'hF;
    bus0.addr_i = 32'h14; bus0.wdata_i = 32'hAAAAAAAA;
    bd_we0 = 1'b1; bd_addr0 = 10'd5; bd_wdata0 = 32'h55555555;
    @(negedge clk);
    check("bd_wr_gnt", bus0.gnt_o, 1'b1);
    @(posedge clk); #1;
    bus0.req_i = 1'b0; bd_we0 = 1'b0;
    xfer0(1'b0, 4'h0, 32'h14, 32'h0, rd, er, gc, rc);
    check("bd_wins", rd, 32'h55555555);

    // Bus read on the edge of a backdoor write returns the old value.
    @(posedge clk); #1;
    bus0.req_i = 1'b1; bus0.we_i = 1'b0; bus0.addr_i = 32'h14;
    bd_we0 = 1'b1; bd_addr0 = 10'd5; bd_wdata0 = 32'h66666666;
    @(negedge clk);
    check("bd_rd_gnt", bus0.gnt_o, 1'b1);
    @(posedge clk); #1;
    bus0.req_i = 1'b0; bd_we0 = 1'b0;
    @(negedge clk);
    check("bd_rd_rvalid", bus0.rvalid_o, 1'b1);
    check("bd_rd_old", bus0.rdata_o, 32'h55555555);
    xfer0(1'b0, 4'h0, 32'h14, 32'h0, rd, er, gc, rc);
    check("bd_rd_new", rd, 32'h66666666);
    check("cnt0_rd", rd_cnt0, 32'd9);
    check("cnt0_wr", wr_cnt0, 32'd3);

    // Grant delay 3, response delay 2.
    pat1(16'h000F, g, r);
    check("t3_gnt", g, 16'h0008);
    check("t3_rv", r, 16'h0020);
    check("t3_rdata", bus1.rdata_o, 32'hCAFE0001);
    pat1(16'h007B, g, r);
    check("t3_restart_gnt", g, 16'h0040);
    check("t3_restart_rv", r, 16'h0100);
    pat1(16'h00FF, g, r);
    check("t3_b2b_gnt", g, 16'h0088);
    check("t3_b2b_rv", r, 16'h0220);
    check("t3_rd_cnt", rd_cnt1, 32'd4);

    // Outstanding limit 2 with response delay 4.
    pat2(16'h03FF, 16'h0000, g, r, o2);
    check("t4_gnt", g, 16'h0333);
    check("t4_rv", r, 16'h3330);
    check("t4_outst_full", o2, 2'd2);
    check("t4_nrsp", 32'(rsp2.size()), 32'd6);
    for (int i = 0; i < 6; i++) begin
      v = (rsp2.size() > i) ? rsp2[i] : 32'hxxxxxxxx;
      check($sformatf("t4_order%0d", i), v, 32'hA0000000 + 32'(i));
    end

    // Reset one cycle before the first response arrives.
    pat2(16'h0003, 16'h0008, g, r, o2);
    check("t6_gnt", g, 16'h0003);
    check("t6_outst_mid", o2, 2'd2);
    check("t6_rv_flushed", r, 16'h0000);
    check("t6_outst", out2, 2'd0);
    check("t6_rd_cnt", rd_cnt2, 32'd0);
    check("t6_wr_cnt", wr_cnt2, 32'd0);
    pat2(16'h0001, 16'h0000, g, r, o2);
    check("t6_post_rv", r, 16'h0010);
    v = (rsp2.size() > 0) ? rsp2[0] : 32'hxxxxxxxx;
    check("t6_mem_kept", v, 32'hA0000000);
    check("t6_post_rd_cnt", rd_cnt2, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/guvm_obi_mem_responder.md
Name: guvm_obi_mem_responder

Overview:
Parametrised, cycle-accurate memory responder model for the core's req/gnt/rvalid instruction and data memory ports. It replaces hand-driven constant grant/rvalid stimulus in the GUVM environment. It provides programmable grant and response latency, limits on outstanding transactions, byte-enable writes, out-of-range error responses, a backdoor preload port and transaction counters. One instance serves one port; instruction-side instances tie we_i and be_i.

Parameters:
ADDR_WIDTH, 32, bus address width
DATA_WIDTH, 32, bus data width; multiple of 8, power of two
MEM_DEPTH, 1024, storage size in DATA_WIDTH words
GNT_DELAY, 0, cycles req_i must be held before gnt_o may assert (0 = same cycle)
RVALID_DELAY, 1, cycles from the grant edge to rvalid_o (>=1)
MAX_OUTSTANDING, 2, granted-but-unanswered transaction limit (>=1)
ERR_DATA, 32'hDEADBEEF, rdata_o value on an error response (zero-extended or truncated to DATA_WIDTH)

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
req_i  in  1  request from core
addr_i  in  ADDR_WIDTH  byte address
we_i  in  1  1 = write
be_i  in  DATA_WIDTH/8  byte enables
wdata_i  in  DATA_WIDTH  write data
gnt_o  out  1  grant (combinational from req_i and state)
rvalid_o  out  1  response valid, one cycle per transaction
rdata_o  out  DATA_WIDTH  read data
err_o  out  1  error flag, qualified by rvalid_o
bd_we_i  in  1  backdoor write strobe
bd_addr_i  in  $clog2(MEM_DEPTH)  backdoor word index
bd_wdata_i  in  DATA_WIDTH  backdoor data, full word
rd_count_o  out  32  granted reads
wr_count_o  out  32  granted writes
outstanding_o  out  $clog2(MAX_OUTSTANDING+1)  in-flight count

Behaviour:
Reset:
- While rst_i is sampled high: gnt_o=0, rvalid_o=0, rdata_o=0, err_o=0, counters=0, outstanding_o=0, delay counter=0.
- The response pipeline is flushed and any pending responses are discarded.
- Memory contents are not cleared.

Grant FSM (IDLE, WAIT):
- IDLE, req_i=0: stay in IDLE.
- IDLE, req_i=1: if GNT_DELAY=0, grant is eligible this cycle. Otherwise go to WAIT and set wait_cnt=1.
- WAIT, req_i=1: increment wait_cnt. Grant is eligible when wait_cnt==GNT_DELAY.
- WAIT, req_i=0: return to IDLE and clear wait_cnt.
- gnt_o = req_i & eligible & (outstanding < MAX_OUTSTANDING).
- If eligible but outstanding is full, hold eligibility until space frees.
- Handshake: req_i&gnt_o at a rising edge. After a handshake the FSM returns to IDLE. A back-to-back req_i restarts the delay.

Decode:
- word = addr_i >> log2(DATA_WIDTH/8). Low address bits are ignored.
- err = (word >= MEM_DEPTH).

Handshake edge:
- Write, no error: mem[word] byte lanes with be_i=1 take wdata_i; other lanes are unchanged. be_i=0 writes nothing but still responds.
- Read: data is captured at the handshake edge (pre-write value, since writes are the same edge).
- Error: no memory access. Captured data = ERR_DATA.
- A descriptor {data, err} enters an in-order delay line. rvalid_o rises exactly RVALID_DELAY cycles after the handshake edge.
- For writes without error, rdata_o = 0.
- rvalid_o deasserts after one cycle; rdata_o/err_o hold the last value until the next response.

Outstanding count:
- +1 on handshake, -1 on rvalid_o.
- Simultaneous handshake and rvalid_o: unchanged.
- The freed slot is usable in the same cycle as rvalid_o.

Backdoor:
- bd_we_i writes the full word at the edge.
- Same edge and same word as a bus write: backdoor value wins.
- A bus read at the same edge returns the pre-write value.

Counters:
- Increment on handshake per type; error transactions count too.
- 32-bit, wrap at 2^32.

Test Plan:
1. Defaults: backdoor mem[3]=32'h002180B3; read addr 32'hC -> gnt_o same cycle, rvalid_o 1 cycle later, rdata_o=32'h002180B3, err_o=0, rd_count_o=1.
2. Byte-enable write: preload mem[0]=32'h11223344; write addr 0, be=4'b0101, wdata=32'hAABBCCDD; read back -> 32'h11BB33DD, wr_count_o=1.
3. GNT_DELAY=3, RVALID_DELAY=2: req held from cycle 0 -> gnt_o only in cycle 3, rvalid_o in cycle 5. Dropping req in cycle 2 and reasserting restarts the count.
4. MAX_OUTSTANDING=2, RVALID_DELAY=4, req held continuously -> two grants, then gnt_o=0 until the first rvalid_o. Grant reasserts in the same cycle as that rvalid_o; responses return in order.
5. Error: read addr 4*MEM_DEPTH -> rvalid_o with err_o=1, rdata_o=32'hDEADBEEF. Write to the same address leaves memory unchanged, err_o=1.
6. Reset mid-flight: grant two reads, assert rst_i one cycle before the first rvalid -> no rvalid_o afterwards, outstanding_o=0, counters=0, memory preserved.
